// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM state stack: default sizes, FSM encoding
// and the field layout of one packed timestep entry.
package lstm_pkg;

    localparam int WIDTH  = 32;
    localparam int FRAC   = 24;
    localparam int DEPTH  = 8;
    localparam int ADDR   = 3;
    localparam int NFIELD = 6;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Entry word is {a,i,f,o,c,h}; a occupies the most significant slice.
    localparam int FLD_A = 5;
    localparam int FLD_I = 4;
    localparam int FLD_F = 3;
    localparam int FLD_O = 2;
    localparam int FLD_C = 1;
    localparam int FLD_H = 0;

    function automatic int fld_lsb(input int fld, input int w);
        return fld * w;
    endfunction

endpackage

// File: rtl/lstm_stack_mem.sv
// Timestep register file: one write port, one full-entry read port and one
// c-only read port, both combinational.
module lstm_stack_mem
    import lstm_pkg::*;
#(
    parameter int WIDTH = lstm_pkg::WIDTH,
    parameter int DEPTH = lstm_pkg::DEPTH,
    parameter int ADDR  = lstm_pkg::ADDR
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDR-1:0]          waddr,
    input  logic [NFIELD*WIDTH-1:0]  wdata,
    input  logic [ADDR-1:0]          raddr_top,
    output logic [NFIELD*WIDTH-1:0]  rdata_top,
    input  logic [ADDR-1:0]          raddr_below,
    output logic [WIDTH-1:0]         c_below
);

    logic [NFIELD*WIDTH-1:0] mem_r [DEPTH];

    // Storage is deliberately not reset; a flush only moves the pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata_top = mem_r[raddr_top];
    assign c_below   = mem_r[raddr_below][fld_lsb(FLD_C, WIDTH) +: WIDTH];

endmodule

// File: rtl/lstm_state_stack.sv
// LIFO store of per-timestep LSTM gate/state values; replays entries newest
// first together with the previous timestep's cell state.
module lstm_state_stack
    import lstm_pkg::*;
#(
    parameter int WIDTH = lstm_pkg::WIDTH,
    parameter int DEPTH = lstm_pkg::DEPTH,
    parameter int ADDR  = lstm_pkg::ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_i,
    input  logic [WIDTH-1:0]  i_f,
    input  logic [WIDTH-1:0]  i_o,
    input  logic [WIDTH-1:0]  i_c,
    input  logic [WIDTH-1:0]  i_h,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [WIDTH-1:0]  o_a,
    output logic [WIDTH-1:0]  o_i,
    output logic [WIDTH-1:0]  o_f,
    output logic [WIDTH-1:0]  o_o,
    output logic [WIDTH-1:0]  o_c,
    output logic [WIDTH-1:0]  o_h,
    output logic [WIDTH-1:0]  o_c_prev,
    output logic [ADDR-1:0]   o_t,
    output logic [ADDR:0]     o_count,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_err
);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ADDR:0]           count_r;
    logic [ADDR:0]           count_nxt_s;
    logic                    empty_s;
    logic                    full_s;
    logic                    push_ok_s;
    logic                    pop_ok_s;
    logic                    err_evt_s;
    logic [ADDR-1:0]         top_idx_s;
    logic [ADDR-1:0]         below_idx_s;
    logic [NFIELD*WIDTH-1:0] wdata_s;
    logic [NFIELD*WIDTH-1:0] top_s;
    logic [WIDTH-1:0]        c_below_s;
    logic [WIDTH-1:0]        c_prev_s;

    assign empty_s     = (count_r == (ADDR+1)'(0));
    assign full_s      = (count_r == (ADDR+1)'(DEPTH));
    assign top_idx_s   = ADDR'(count_r - (ADDR+1)'(1));
    assign below_idx_s = ADDR'(count_r - (ADDR+1)'(2));
    assign wdata_s     = {i_a, i_i, i_f, i_o, i_c, i_h};
    assign c_prev_s    = (count_r >= (ADDR+1)'(2)) ? c_below_s : {WIDTH{1'b0}};
    assign o_count     = count_r;

    lstm_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR  (ADDR)
    ) u_mem (
        .clk         (clk),
        .we          (push_ok_s && !i_clear),
        .waddr       (count_r[ADDR-1:0]),
        .wdata       (wdata_s),
        .raddr_top   (top_idx_s),
        .rdata_top   (top_s),
        .raddr_below (below_idx_s),
        .c_below     (c_below_s)
    );

    // Request arbitration: simultaneous push+pop and any illegal request is an error.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        err_evt_s = 1'b0;
        if (i_push && i_pop) begin
            err_evt_s = 1'b1;
        end else if (i_push) begin
            if (state_r == FILL && !full_s) begin
                push_ok_s = 1'b1;
            end else begin
                err_evt_s = 1'b1;
            end
        end else if (i_pop) begin
            if (!empty_s) begin
                pop_ok_s = 1'b1;
            end else begin
                err_evt_s = 1'b1;
            end
        end else begin
            err_evt_s = 1'b0;
        end
    end

    // Next count and FSM state; the last pop drops straight back to FILL.
    always_comb begin
        count_nxt_s = count_r;
        state_nxt_s = state_r;
        if (push_ok_s) begin
            count_nxt_s = count_r + (ADDR+1)'(1);
        end else if (pop_ok_s) begin
            count_nxt_s = count_r - (ADDR+1)'(1);
            if (count_r == (ADDR+1)'(1)) begin
                state_nxt_s = FILL;
            end else begin
                state_nxt_s = DRAIN;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Control state, status flags and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FILL;
            count_r <= '0;
            o_empty <= 1'b1;
            o_full  <= 1'b0;
            o_err   <= 1'b0;
            o_valid <= 1'b0;
        end else if (i_clear) begin
            state_r <= FILL;
            count_r <= '0;
            o_empty <= 1'b1;
            o_full  <= 1'b0;
            o_err   <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            o_empty <= (count_nxt_s == (ADDR+1)'(0));
            o_full  <= (count_nxt_s == (ADDR+1)'(DEPTH));
            o_valid <= pop_ok_s;
            if (err_evt_s) begin
                o_err <= 1'b1;
            end
        end
    end

    // Popped data registers hold until the next accepted pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_a      <= '0;
            o_i      <= '0;
            o_f      <= '0;
            o_o      <= '0;
            o_c      <= '0;
            o_h      <= '0;
            o_c_prev <= '0;
            o_t      <= '0;
        end else if (pop_ok_s && !i_clear) begin
            o_a      <= top_s[fld_lsb(FLD_A, WIDTH) +: WIDTH];
            o_i      <= top_s[fld_lsb(FLD_I, WIDTH) +: WIDTH];
            o_f      <= top_s[fld_lsb(FLD_F, WIDTH) +: WIDTH];
            o_o      <= top_s[fld_lsb(FLD_O, WIDTH) +: WIDTH];
            o_c      <= top_s[fld_lsb(FLD_C, WIDTH) +: WIDTH];
            o_h      <= top_s[fld_lsb(FLD_H, WIDTH) +: WIDTH];
            o_c_prev <= c_prev_s;
            o_t      <= top_idx_s;
        end
    end

endmodule

// File: tb/tb_lstm_state_stack.sv
// Directed, table-driven bench for lstm_state_stack with hand-computed
// expectations plus sequences for full, LIFO integrity and async reset.
module tb_lstm_state_stack;

    logic        clk;
    logic        rst;
    logic        i_clear;
    logic        i_push;
    logic        i_pop;
    logic [31:0] i_a, i_i, i_f, i_o, i_c, i_h;
    logic        o_valid;
    logic [31:0] o_a, o_i, o_f, o_o, o_c, o_h, o_c_prev;
    logic [2:0]  o_t;
    logic [3:0]  o_count;
    logic        o_empty, o_full, o_err;

    int tests = 0;
    int fails = 0;

    lstm_state_stack #(.WIDTH(32), .DEPTH(8), .ADDR(3)) dut (
        .clk(clk), .rst(rst), .i_clear(i_clear), .i_push(i_push),
        .i_a(i_a), .i_i(i_i), .i_f(i_f), .i_o(i_o), .i_c(i_c), .i_h(i_h),
        .i_pop(i_pop), .o_valid(o_valid),
        .o_a(o_a), .o_i(o_i), .o_f(o_f), .o_o(o_o), .o_c(o_c), .o_h(o_h),
        .o_c_prev(o_c_prev), .o_t(o_t), .o_count(o_count),
        .o_empty(o_empty), .o_full(o_full), .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Other gate fields are derived from c so every field is distinguishable.
    function automatic logic [31:0] mk_a(input logic [31:0] c); return c ^ 32'hA5A5_0000; endfunction
    function automatic logic [31:0] mk_i(input logic [31:0] c); return c + 32'h0000_0001; endfunction
    function automatic logic [31:0] mk_f(input logic [31:0] c); return ~c; endfunction
    function automatic logic [31:0] mk_o(input logic [31:0] c); return {c[15:0], c[31:16]}; endfunction
    function automatic logic [31:0] mk_h(input logic [31:0] c); return 32'h0000_0000 - c; endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_fields(input string nm, input logic [31:0] c);
        chk({nm, ".a"}, o_a, mk_a(c));
        chk({nm, ".i"}, o_i, mk_i(c));
        chk({nm, ".f"}, o_f, mk_f(c));
        chk({nm, ".o"}, o_o, mk_o(c));
        chk({nm, ".h"}, o_h, mk_h(c));
    endtask

    task automatic step(input logic push, input logic pop, input logic clr, input logic [31:0] c);
        i_push  = push;
        i_pop   = pop;
        i_clear = clr;
        i_c = c; i_a = mk_a(c); i_i = mk_i(c); i_f = mk_f(c); i_o = mk_o(c); i_h = mk_h(c);
        @(posedge clk);
        #1;
        i_push  = 1'b0;
        i_pop   = 1'b0;
        i_clear = 1'b0;
    endtask

    typedef struct {
        logic        push, pop, clr;
        logic [31:0] c;
        logic        ev;
        logic [31:0] ec, ecp;
        logic [2:0]  et;
        logic [3:0]  ecnt;
        logic        eerr, eem, efu;
    } vec_t;

    vec_t vecs[19];

    initial begin
        rst = 1'b1; i_clear = 1'b0; i_push = 1'b0; i_pop = 1'b0;
        i_a = '0; i_i = '0; i_f = '0; i_o = '0; i_c = '0; i_h = '0;

        //                push  pop   clr   c              ev    ec             ecp            et    cnt   err   emp   full
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 32'h0,         32'h0,         3'd0, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0080_0000, 1'b0, 32'h0,         32'h0,         3'd0, 4'd2, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0040_0000, 1'b0, 32'h0,         32'h0,         3'd0, 4'd3, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_0000, 32'h0080_0000, 3'd2, 4'd2, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0080_0000, 32'h0100_0000, 3'd1, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0100_0000, 32'h0,         3'd0, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0100_0000, 32'h0,         3'd0, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0011, 1'b0, 32'h0100_0000, 32'h0,         3'd0, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0022, 1'b0, 32'h0100_0000, 32'h0,         3'd0, 4'd2, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0033, 1'b0, 32'h0100_0000, 32'h0,         3'd0, 4'd2, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0100_0000, 32'h0,         3'd0, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 32'h0100_0000, 32'h0,         3'd0, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0000_0200, 1'b0, 32'h0100_0000, 32'h0,         3'd0, 4'd2, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0000_0300, 1'b0, 32'h0100_0000, 32'h0,         3'd0, 4'd3, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0000_0400, 1'b0, 32'h0100_0000, 32'h0,         3'd0, 4'd4, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0400, 32'h0000_0300, 3'd3, 4'd3, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 32'h0000_0999, 1'b0, 32'h0000_0400, 32'h0000_0300, 3'd3, 4'd3, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0300, 32'h0000_0200, 3'd2, 4'd2, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0000_0300, 32'h0000_0200, 3'd2, 4'd0, 1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        chk("rst.valid", {31'b0, o_valid}, 32'd0);
        chk("rst.count", {28'b0, o_count}, 32'd0);
        chk("rst.empty", {31'b0, o_empty}, 32'd1);
        chk("rst.full",  {31'b0, o_full},  32'd0);
        chk("rst.err",   {31'b0, o_err},   32'd0);
        chk("rst.c",     o_c,              32'd0);
        chk("rst.a",     o_a,              32'd0);

        // Pop on an empty stack straight after reset.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("epop.valid",  {31'b0, o_valid}, 32'd0);
        chk("epop.err",    {31'b0, o_err},   32'd1);
        chk("epop.c",      o_c,              32'd0);
        chk("epop.c_prev", o_c_prev,         32'd0);
        chk("epop.t",      {29'b0, o_t},     32'd0);
        chk("epop.count",  {28'b0, o_count}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("epop.clr_err", {31'b0, o_err},  32'd0);

        for (int v = 0; v < 19; v++) begin
            string nm;
            step(vecs[v].push, vecs[v].pop, vecs[v].clr, vecs[v].c);
            nm = $sformatf("vec%0d", v);
            chk({nm, ".valid"},  {31'b0, o_valid}, {31'b0, vecs[v].ev});
            chk({nm, ".c"},      o_c,              vecs[v].ec);
            chk({nm, ".c_prev"}, o_c_prev,         vecs[v].ecp);
            chk({nm, ".t"},      {29'b0, o_t},     {29'b0, vecs[v].et});
            chk({nm, ".count"},  {28'b0, o_count}, {28'b0, vecs[v].ecnt});
            chk({nm, ".err"},    {31'b0, o_err},   {31'b0, vecs[v].eerr});
            chk({nm, ".empty"},  {31'b0, o_empty}, {31'b0, vecs[v].eem});
            chk({nm, ".full"},   {31'b0, o_full},  {31'b0, vecs[v].efu});
            if (vecs[v].ev) chk_fields(nm, vecs[v].ec);
        end

        // Fill to DEPTH, overflow, then drain all eight entries.
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, 32'(k + 1) << 20);
        chk("full.count", {28'b0, o_count}, 32'd8);
        chk("full.full",  {31'b0, o_full},  32'd1);
        chk("full.err0",  {31'b0, o_err},   32'd0);
        step(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        chk("ovf.count", {28'b0, o_count}, 32'd8);
        chk("ovf.err",   {31'b0, o_err},   32'd1);
        chk("ovf.valid", {31'b0, o_valid}, 32'd0);
        for (int k = 7; k >= 0; k--) begin
            string nm;
            step(1'b0, 1'b1, 1'b0, 32'h0);
            nm = $sformatf("drain%0d", k);
            chk({nm, ".valid"},  {31'b0, o_valid}, 32'd1);
            chk({nm, ".c"},      o_c,              32'(k + 1) << 20);
            chk({nm, ".c_prev"}, o_c_prev,         (k > 0) ? (32'(k) << 20) : 32'd0);
            chk({nm, ".t"},      {29'b0, o_t},     32'(k));
            chk({nm, ".count"},  {28'b0, o_count}, 32'(k));
            chk_fields(nm, 32'(k + 1) << 20);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("drain.idle_valid", {31'b0, o_valid}, 32'd0);
        chk("drain.empty",      {31'b0, o_empty}, 32'd1);

        // Async reset while draining with five entries left.
        step(1'b0, 1'b0, 1'b1, 32'h0);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 32'(k + 1) << 16);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("ar.pre_valid", {31'b0, o_valid}, 32'd1);
        chk("ar.pre_count", {28'b0, o_count}, 32'd5);
        chk("ar.pre_c",     o_c,              32'h0006_0000);
        rst = 1'b1;
        #1;
        chk("ar.valid",  {31'b0, o_valid}, 32'd0);
        chk("ar.count",  {28'b0, o_count}, 32'd0);
        chk("ar.empty",  {31'b0, o_empty}, 32'd1);
        chk("ar.c",      o_c,              32'd0);
        chk("ar.a",      o_a,              32'd0);
        chk("ar.c_prev", o_c_prev,         32'd0);
        chk("ar.t",      {29'b0, o_t},     32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("ar.pop_valid", {31'b0, o_valid}, 32'd0);
        chk("ar.pop_err",   {31'b0, o_err},   32'd1);
        chk("ar.pop_count", {28'b0, o_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lstm_state_stack.md
# lstm_state_stack

Per-timestep gate and state storage sitting directly downstream of `lstm_cell`. During the forward pass it captures that timestep's a, i, f, o, c and h values. During backpropagation-through-time it replays the timesteps in reverse order (LIFO). Each replayed entry is presented together with c(t-1), so the gradient stage never has to recompute or re-read neighbouring entries.

## Interface

Parameters:
- `WIDTH`, 32: data width, signed Q8.24 fixed point.
- `DEPTH`, 8: maximum number of stored timesteps; must be a power of two, ≥2.
- `ADDR`, 3: pointer width; equals log2(DEPTH).

Ports:
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `i_clear`, in, 1: synchronous flush; empties the stack and clears error flags.
- `i_push`, in, 1: capture `i_a`..`i_h` as a new timestep entry.
- `i_a`, `i_i`, `i_f`, `i_o`, `i_c`, `i_h`, in, WIDTH each: `lstm_cell` outputs o_a, o_i, o_f, o_o, o_c, o_h.
- `i_pop`, in, 1: request the most recent entry.
- `o_valid`, out, 1: one-cycle pulse; the output data below is fresh.
- `o_a`, `o_i`, `o_f`, `o_o`, `o_c`, `o_h`, out, WIDTH each: popped entry.
- `o_c_prev`, out, WIDTH: c of the entry below the popped one; 0 when the popped entry is timestep 0.
- `o_t`, out, ADDR: timestep index of the popped entry.
- `o_count`, out, ADDR+1: number of stored entries.
- `o_empty`, `o_full`, out, 1: o_empty = (count==0); o_full = (count==DEPTH).
- `o_err`, out, 1: sticky protocol-error flag.

## Operation

- The FSM has two states, `FILL` (reset state) and `DRAIN`.
- `FILL`:
  - A push while not full writes entry[count] and increments count.
  - A push while full is dropped and sets o_err.
  - A pop while count>0 moves the FSM to `DRAIN` and is served in the same cycle.
  - A pop while empty is dropped and sets o_err.
- `DRAIN`:
  - A pop with count>0 reads entry[count-1] and c-entry[count-2] (0 if count==1), decrements count, and sets o_t = count-1.
  - When count reaches 0 the FSM returns to `FILL`.
  - A push in `DRAIN` is dropped and sets o_err.
- Simultaneous push and pop in either state:
  - Both are dropped and o_err is set.
  - Count, pointers and the FSM state are unchanged.
- i_clear has priority over push and pop. It sets count to 0, moves the FSM to `FILL`, and clears o_err. Memory contents are not cleared.
- Data is stored verbatim; there is no arithmetic, saturation or sign change.
- o_a..o_h, o_c_prev and o_t hold their last popped values until the next successful pop.
- o_err stays set until i_clear or rst.

## Timing

- Push: entry is written at the capturing edge; o_count updates at the same edge.
- Pop latency is 1 cycle. A pop accepted at edge N drives o_valid high and updates the data outputs after edge N, for exactly one cycle.
- o_valid is never asserted for a dropped request.
- Back-to-back pops on every cycle are supported, giving one entry per cycle.
- Reset values:
  - count 0, FSM `FILL`.
  - o_valid, o_err, all data outputs, o_t and o_count are 0.
  - o_empty 1, o_full 0.
- rst asserted mid-drain aborts immediately. After release the stack is empty and in `FILL`.
- Wrap-around: pointers never wrap; count saturates at DEPTH and at 0 by the drop rules above.

## Structure

- Shared package `lstm_pkg`:
  - `WIDTH`, `FRAC`=24, `DEPTH` defaults.
  - FSM state encoding (`FILL`=0, `DRAIN`=1).
  - Gate field order constant {a,i,f,o,c,h} for packing a 6×WIDTH entry word.
- Sub-module `lstm_stack_mem`: register file of DEPTH × 6·WIDTH with one write port and two asynchronous read ports.
  - Port 1 reads the full entry at count-1.
  - Port 2 reads only the c field at count-2.
  - Output registers sit in `lstm_state_stack`.

## Test plan

- Reset, then 3 pushes with c = 0x01000000, 0x00800000, 0x00400000, then 3 pops:
  - o_c sequence 0x00400000, 0x00800000, 0x01000000.
  - o_c_prev sequence 0x00800000, 0x01000000, 0.
  - o_t sequence 2, 1, 0; one o_valid pulse per pop.
  - After the last pop: o_empty=1 and the FSM is back in `FILL`.
- Push DEPTH=8 entries with o_full=1, then a 9th push: entry dropped, count=8, o_err=1; popping 8 returns the original 8 entries intact.
- Pop on an empty stack after reset: o_valid stays 0, o_err=1, all outputs remain 0.
- Push and pop in the same cycle with count=2: count stays 2, o_valid stays 0, o_err=1; i_clear then gives count 0 and o_err 0.
- 4 pushes, 1 pop, then a push: the push is dropped (`DRAIN`) and o_err=1; the next pop returns the 3rd entry with o_c_prev equal to the 2nd entry's c.
- Assert rst asynchronously mid-clock while draining with count=5: all outputs go to reset values without a clock edge; after release a pop sets o_err and produces no o_valid.
